// File: rtl/spectro_readout_scheduler.sv
// Serial readout sequencer for one spectrogram frame: timestamp halves on two lanes, then ch1/ch2 bin words.
// Define READOUT_PARITY_EN to append an even-parity bit after every serialized word.
module spectro_readout_scheduler #(
  parameter int TS_W   = 16,
  parameter int CH_W   = 7,
  parameter int N_BINS = 8,
  parameter int ADDR_W = 3
) (
  input  logic              input_acquisition_clk,
  input  logic              reset,
  input  logic              readout_en,
  input  logic              frame_ready,
  input  logic              shift_tick,
  input  logic [TS_W-1:0]   ts_value,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [CH_W-1:0]   mem_rd_data_ch1,
  input  logic [CH_W-1:0]   mem_rd_data_ch2,
  output logic [1:0]        serial_out,
  output logic              sl_time,
  output logic              sl_ch,
  output logic              sending_data,
  output logic              frame_done,
  output logic              overrun
);

  localparam int HALF = TS_W / 2;
`ifdef READOUT_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int TS_LEN = HALF + PAR_BITS;
  localparam int CH_LEN = CH_W + PAR_BITS;
  localparam int SR_W   = (HALF > CH_W) ? HALF : CH_W;
  localparam int CNT_W  = $clog2(SR_W + 2);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BINS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_TS  = 3'd1;
  localparam logic [2:0] S_SHIFT_TS = 3'd2;
  localparam logic [2:0] S_FETCH    = 3'd3;
  localparam logic [2:0] S_LOAD_CH  = 3'd4;
  localparam logic [2:0] S_SHIFT_CH = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]        state;
  logic [SR_W-1:0]   sr0, sr1;
  logic              par0, par1;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic              last_bit;
  logic              par_slot;

  // Words are left-aligned in the shift registers so the MSB always sits at SR_W-1.
  assign last_bit = (bit_cnt == ((state == S_SHIFT_TS) ? CNT_W'(TS_LEN - 1) : CNT_W'(CH_LEN - 1)));
`ifdef READOUT_PARITY_EN
  assign par_slot = (bit_cnt == ((state == S_SHIFT_TS) ? CNT_W'(HALF) : CNT_W'(CH_W)));
`else
  assign par_slot = 1'b0;
`endif

  always_ff @(posedge input_acquisition_clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      sr0          <= '0;
      sr1          <= '0;
      par0         <= 1'b0;
      par1         <= 1'b0;
      bit_cnt      <= '0;
      word_idx     <= '0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      serial_out   <= '0;
      sl_time      <= 1'b0;
      sl_ch        <= 1'b0;
      sending_data <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (frame_ready && readout_en && (state != S_IDLE))
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (frame_ready && readout_en) begin
            sr0          <= SR_W'(ts_value[TS_W-1:HALF]) << (SR_W - HALF);
            sr1          <= SR_W'(ts_value[HALF-1:0]) << (SR_W - HALF);
            par0         <= 1'b0;
            par1         <= 1'b0;
            sending_data <= 1'b1;
            sl_time      <= 1'b1;
            state        <= S_LOAD_TS;
          end
        end
        S_LOAD_TS: begin
          sl_time <= 1'b0;
          bit_cnt <= '0;
          state   <= S_SHIFT_TS;
        end
        S_SHIFT_TS, S_SHIFT_CH: begin
          if (shift_tick) begin
            if (par_slot) begin
              serial_out <= {par1, par0};
            end else begin
              serial_out <= {sr1[SR_W-1], sr0[SR_W-1]};
              sr0        <= sr0 << 1;
              sr1        <= sr1 << 1;
              par0       <= par0 ^ sr0[SR_W-1];
              par1       <= par1 ^ sr1[SR_W-1];
            end
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              if (state == S_SHIFT_TS) begin
                word_idx  <= '0;
                mem_addr  <= '0;
                mem_rd_en <= 1'b1;
                state     <= S_FETCH;
              end else if (word_idx == LAST_IDX) begin
                frame_done   <= 1'b1;
                sending_data <= 1'b0;
                state        <= S_DONE;
              end else begin
                word_idx  <= word_idx + 1'b1;
                mem_addr  <= word_idx + 1'b1;
                mem_rd_en <= 1'b1;
                state     <= S_FETCH;
              end
            end
          end
        end
        S_FETCH: begin
          mem_rd_en <= 1'b0;
          sl_ch     <= 1'b1;
          state     <= S_LOAD_CH;
        end
        S_LOAD_CH: begin
          // Read data is valid this cycle, one cycle after the read strobe.
          sr0     <= SR_W'(mem_rd_data_ch1) << (SR_W - CH_W);
          sr1     <= SR_W'(mem_rd_data_ch2) << (SR_W - CH_W);
          par0    <= 1'b0;
          par1    <= 1'b0;
          bit_cnt <= '0;
          sl_ch   <= 1'b0;
          state   <= S_SHIFT_CH;
        end
        S_DONE: begin
          frame_done <= 1'b0;
          serial_out <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spectro_readout_scheduler.sv
// Self-checking bench for spectro_readout_scheduler: protocol monitor plus lane-stream reference model.
module tb_spectro_readout_scheduler;

`ifdef READOUT_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB  = 4;
  localparam int TSL = 8 + PAR;
  localparam int CHL = 7 + PAR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       readout_en = 1'b1;
  logic       frame_ready = 1'b0;
  logic       shift_tick = 1'b0;
  logic [15:0] ts_value = '0;
  logic       mem_rd_en;
  logic [1:0] mem_addr;
  logic [6:0] rd1 = '0, rd2 = '0;
  logic [1:0] serial_out;
  logic       sl_time, sl_ch, sending_data, frame_done, overrun;

  logic [6:0] m1 [NB];
  logic [6:0] m2 [NB];

  int n_chk = 0, n_pass = 0;
  int n_slt = 0, n_slch = 0, n_done = 0, ncap = 0, rem = 0;
  logic [31:0] addr_log = '0;
  logic [63:0] cap0 = '0, cap1 = '0;

  spectro_readout_scheduler #(.TS_W(16), .CH_W(7), .N_BINS(NB), .ADDR_W(2)) dut (
    .input_acquisition_clk(clk),
    .reset(rst),
    .readout_en(readout_en),
    .frame_ready(frame_ready),
    .shift_tick(shift_tick),
    .ts_value(ts_value),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rd_data_ch1(rd1),
    .mem_rd_data_ch2(rd2),
    .serial_out(serial_out),
    .sl_time(sl_time),
    .sl_ch(sl_ch),
    .sending_data(sending_data),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      rd1 <= m1[mem_addr];
      rd2 <= m2[mem_addr];
    end
  end

  // Free-running serial tick, one cycle high every 4 cycles.
  initial forever begin
    repeat (3) @(negedge clk);
    shift_tick = 1'b1;
    @(negedge clk);
    shift_tick = 1'b0;
  end

  // Protocol monitor: a load strobe frames the next word; each later tick yields one bit per lane.
  initial forever begin
    @(posedge clk);
    if (sl_time) n_slt++;
    if (sl_ch) n_slch++;
    if (frame_done) n_done++;
    if (mem_rd_en) addr_log = (addr_log << 4) | 32'(mem_addr);
    if (rst) rem = 0;
    else if (sl_time) rem = TSL;
    else if (sl_ch) rem = CHL;
    else if (shift_tick && rem > 0) begin
      rem--;
      #1;
      cap0 = {cap0[62:0], serial_out[0]};
      cap1 = {cap1[62:0], serial_out[1]};
      ncap++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [15:0] ts, output logic [63:0] e0, output logic [63:0] e1);
    e0 = '0;
    e1 = '0;
    for (int b = 7; b >= 0; b--) begin
      e0 = {e0[62:0], ts[8+b]};
      e1 = {e1[62:0], ts[b]};
    end
    if (PAR == 1) begin
      e0 = {e0[62:0], ^ts[15:8]};
      e1 = {e1[62:0], ^ts[7:0]};
    end
    for (int i = 0; i < NB; i++) begin
      for (int b = 6; b >= 0; b--) begin
        e0 = {e0[62:0], m1[i][b]};
        e1 = {e1[62:0], m2[i][b]};
      end
      if (PAR == 1) begin
        e0 = {e0[62:0], ^m1[i]};
        e1 = {e1[62:0], ^m2[i]};
      end
    end
  endfunction

  task automatic start_frame(input logic [15:0] ts);
    n_slt = 0; n_slch = 0; n_done = 0; ncap = 0;
    addr_log = '0; cap0 = '0; cap1 = '0;
    @(negedge clk);
    ts_value = ts;
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    ts_value = 16'($urandom);
    chk("busy_after_accept", sending_data, 1'b1);
  endtask

  task automatic finish_frame(input logic [15:0] ts);
    logic [63:0] e0, e1;
    int to;
    to = 0;
    while (n_done == 0 && to < 3000) begin
      @(negedge clk);
      to++;
    end
    chk("frame_done_timeout", (to < 3000), 1'b1);
    chk("sending_data_drop", sending_data, 1'b0);
    repeat (20) @(negedge clk);
    model(ts, e0, e1);
    chk("lane0_stream", cap0, e0);
    chk("lane1_stream", cap1, e1);
    chk("bit_count", ncap, TSL + NB * CHL);
    chk("sl_time_pulses", n_slt, 1);
    chk("sl_ch_pulses", n_slch, NB);
    chk("frame_done_pulses", n_done, 1);
    chk("addr_sequence", addr_log, 32'h0123);
    chk("mem_addr_hold", mem_addr, 2'd3);
    chk("serial_idle", serial_out, 2'b00);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) begin
      m1[i] = 7'($urandom);
      m2[i] = 7'($urandom);
    end
  endtask

  initial begin
    logic [15:0] ts;
    int to;
    fill_random();
    repeat (3) @(negedge clk);
    chk("rst_serial", serial_out, 2'b00);
    chk("rst_sending", sending_data, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {mem_rd_en, mem_addr, sl_time, sl_ch, frame_done, overrun}, '0);

    // Reference frame from the datasheet example.
    m1[0] = 7'h55; m1[1] = 7'h01; m1[2] = 7'h7F; m1[3] = 7'h00;
    m2[0] = 7'h2A;
    start_frame(16'hA55A);
    finish_frame(16'hA55A);
    chk("no_overrun_clean", overrun, 1'b0);

    // Parity example word and random others.
    fill_random();
    m1[0] = 7'h07;
    start_frame(16'hA5C3);
    finish_frame(16'hA5C3);

    // Disabled readout ignores frame_ready entirely.
    n_slt = 0;
    readout_en = 1'b0;
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    repeat (40) @(negedge clk);
    chk("disabled_no_sl_time", n_slt, 0);
    chk("disabled_idle", sending_data, 1'b0);
    chk("disabled_no_overrun", overrun, 1'b0);
    readout_en = 1'b1;

    // Asynchronous reset in the middle of a channel word.
    fill_random();
    start_frame(16'($urandom));
    to = 0;
    while (n_slch < 2 && to < 1000) begin
      @(negedge clk);
      to++;
    end
    chk("reach_shift_ch", (to < 1000), 1'b1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sending", sending_data, 1'b0);
    chk("midrst_outputs", {serial_out, mem_rd_en, mem_addr, sl_time, sl_ch, frame_done, overrun}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    ts = 16'($urandom);
    start_frame(ts);
    finish_frame(ts);

    // Second frame_ready while shifting the timestamp is dropped and flagged.
    fill_random();
    ts = 16'($urandom);
    start_frame(ts);
    repeat (6) @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("overrun_set", overrun, 1'b1);
    finish_frame(ts);
    chk("overrun_sticky", overrun, 1'b1);

    // Randomized frames.
    for (int k = 0; k < 3; k++) begin
      fill_random();
      ts = 16'($urandom);
      start_frame(ts);
      finish_frame(ts);
    end
    chk("overrun_still_sticky", overrun, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
